// File: rtl/shift_arbiter.sv
// rtl/shift_arbiter.sv - two-requester round-robin arbiter sharing one right-shift core for SLL/SRL/SRA
module shift_arbiter_rsh_core #(
    parameter int DATA_W  = 32,
    parameter int SHAMT_W = 5
) (
    input  logic [DATA_W-1:0]  din,
    input  logic [SHAMT_W-1:0] shamt,
    output logic [DATA_W-1:0]  dout
);
    logic [SHAMT_W:0][DATA_W-1:0] stage;

    assign stage[0] = din;

    // Logarithmic barrel: stage s moves the word down by 2**s with zero fill.
    for (genvar s = 0; s < SHAMT_W; s++) begin : g_stage
        localparam int K = 2 ** s;
        assign stage[s+1] = shamt[s] ? {{K{1'b0}}, stage[s][DATA_W-1:K]} : stage[s];
    end

    assign dout = stage[SHAMT_W];
endmodule

module shift_arbiter #(
    parameter int DATA_W  = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [1:0]         req_valid,
    output logic [1:0]         req_ready,
    input  logic [1:0]         req_op0,
    input  logic [DATA_W-1:0]  req_data0,
    input  logic [SHAMT_W-1:0] req_shamt0,
    input  logic [1:0]         req_op1,
    input  logic [DATA_W-1:0]  req_data1,
    input  logic [SHAMT_W-1:0] req_shamt1,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic               rsp_id,
    output logic [DATA_W-1:0]  rsp_data,
    output logic               busy
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRA = 2'b11;

    state_t             state, state_nxt;
    logic               rr_ptr;
    logic [1:0]         op_q;
    logic [DATA_W-1:0]  data_q;
    logic [SHAMT_W-1:0] shamt_q;
    logic               id_q;

    logic               accept;
    logic               win_id;
    logic [DATA_W-1:0]  core_in, core_out, result, sra_mask;
    logic [DATA_W-1:0]  data_rev, core_rev;

    // Ready is gated by rst_n so nothing looks accepted while reset is held.
    always_comb begin
        accept    = rst_n && (state == IDLE) && (req_valid != 2'b00);
        win_id    = (req_valid == 2'b11) ? rr_ptr : req_valid[1];
        req_ready = 2'b00;
        if (accept) begin
            req_ready = win_id ? 2'b10 : 2'b01;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = EXEC;
            EXEC:    state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr   <= 1'b0;
            op_q     <= 2'b00;
            data_q   <= '0;
            shamt_q  <= '0;
            id_q     <= 1'b0;
            rsp_data <= '0;
            rsp_id   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    id_q    <= win_id;
                    op_q    <= win_id ? req_op1    : req_op0;
                    data_q  <= win_id ? req_data1  : req_data0;
                    shamt_q <= win_id ? req_shamt1 : req_shamt0;
                end
                EXEC: begin
                    rsp_data <= result;
                    rsp_id   <= id_q;
                end
                RESP: if (rsp_ready) begin
                    rr_ptr <= ~rsp_id;
                end
                default: ;
            endcase
        end
    end

    // SLL rides the right-shift core through bit reversal; SRA ORs in a sign mask of the top shamt bits.
    always_comb begin
        for (int i = 0; i < DATA_W; i++) begin
            data_rev[i] = data_q[DATA_W-1-i];
            core_rev[i] = core_out[DATA_W-1-i];
            sra_mask[i] = (i + int'(shamt_q)) >= DATA_W;
        end
    end

    assign core_in = (op_q == OP_SLL) ? data_rev : data_q;

    shift_arbiter_rsh_core #(
        .DATA_W  (DATA_W),
        .SHAMT_W (SHAMT_W)
    ) u_core (
        .din   (core_in),
        .shamt (shamt_q),
        .dout  (core_out)
    );

    always_comb begin
        result = core_out;
        if (op_q == OP_SLL) begin
            result = core_rev;
        end else if (op_q == OP_SRA && data_q[DATA_W-1]) begin
            result = core_out | sra_mask;
        end
    end

    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE);
endmodule

// File: tb/tb_shift_arbiter.sv
// tb/tb_shift_arbiter.sv - directed and random checks of shift_arbiter against a behavioural model
module tb_shift_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [1:0]  req_op0, req_op1;
    logic [31:0] req_data0, req_data1;
    logic [4:0]  req_shamt0, req_shamt1;
    logic        rsp_valid, rsp_ready, rsp_id, busy;
    logic [31:0] rsp_data;

    int n_vec  = 0;
    int n_fail = 0;
    int exp_prio = 0;

    always #5 clk = ~clk;

    shift_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op0    (req_op0),
        .req_data0  (req_data0),
        .req_shamt0 (req_shamt0),
        .req_op1    (req_op1),
        .req_data1  (req_data1),
        .req_shamt1 (req_shamt1),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .busy       (busy)
    );

    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] d, input logic [4:0] sh);
        case (op)
            2'b00:   return d << sh;
            2'b11:   return 32'($signed(d) >>> sh);
            default: return d >> sh;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called with the DUT idle, just after a falling edge; returns in the same phase, idle again.
    task automatic do_op(input logic [1:0] vmask, input logic [1:0] op, input logic [31:0] d,
                         input logic [4:0] sh, input int hold, input bit keep);
        int          win;
        logic [31:0] exp_d;
        win   = (vmask == 2'b11) ? exp_prio : (vmask[1] ? 1 : 0);
        exp_d = model(op, d, sh);
        req_valid = vmask;
        req_op0 = op; req_data0 = d; req_shamt0 = sh;
        req_op1 = op; req_data1 = d; req_shamt1 = sh;
        rsp_ready = (hold == 0);
        #1;
        chk("grant", {30'd0, req_ready}, (win == 1) ? 32'd2 : 32'd1);
        @(negedge clk);
        if (!keep) req_valid = 2'b00;
        #1;
        chk("exec_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("exec_busy", {31'd0, busy}, 32'd1);
        chk("exec_ready", {30'd0, req_ready}, 32'd0);
        @(negedge clk);
        #1;
        chk("rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("rsp_id", {31'd0, rsp_id}, 32'(win));
        chk("rsp_data", rsp_data, exp_d);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            #1;
            chk("hold_valid", {31'd0, rsp_valid}, 32'd1);
            chk("hold_id", {31'd0, rsp_id}, 32'(win));
            chk("hold_data", rsp_data, exp_d);
            chk("hold_ready", {30'd0, req_ready}, 32'd0);
            if (h == hold - 1) rsp_ready = 1'b1;
        end
        @(negedge clk);
        #1;
        chk("idle_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("idle_busy", {31'd0, busy}, 32'd0);
        exp_prio = 1 - win;
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = 2'b00;
        req_op0 = 2'b00; req_data0 = '0; req_shamt0 = '0;
        req_op1 = 2'b00; req_data1 = '0; req_shamt1 = '0;
        rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("rst_rsp_id", {31'd0, rsp_id}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_ready", {30'd0, req_ready}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_prio = 0;
        @(negedge clk);
        #1;

        // Both requesters valid straight out of reset and held: grants alternate 0,1,0,1.
        for (int k = 0; k < 4; k++) begin
            do_op(2'b11, 2'b01, 32'h1234_5678 + 32'(k), 5'(k), 0, 1'b1);
            chk("rr_order", 32'(exp_prio), (k % 2 == 0) ? 32'd1 : 32'd0);
        end
        req_valid = 2'b00;

        do_op(2'b01, 2'b01, 32'h8000_0000, 5'd31, 0, 1'b0);
        chk("srl31_const", rsp_data, 32'h0000_0001);
        do_op(2'b10, 2'b11, 32'h8000_0000, 5'd4, 0, 1'b0);
        chk("sra4_const", rsp_data, 32'hF800_0000);
        do_op(2'b10, 2'b00, 32'h0000_0003, 5'd30, 0, 1'b0);
        chk("sll30_const", rsp_data, 32'hC000_0000);
        do_op(2'b01, 2'b10, 32'h0000_00F0, 5'd4, 0, 1'b0);
        chk("op10_const", rsp_data, 32'h0000_000F);

        for (int op = 0; op < 4; op++) begin
            do_op(2'b01, 2'(op), 32'hA5A5_5A5A, 5'd0, 0, 1'b0);
            chk("shamt0", rsp_data, 32'hA5A5_5A5A);
        end

        // Stalled response with both requesters pushing.
        do_op(2'b11, 2'b11, 32'h9000_0001, 5'd7, 5, 1'b1);
        req_valid = 2'b00;

        for (int n = 0; n < 1000; n++) begin
            logic [1:0] vm;
            vm = 2'($urandom_range(1, 3));
            do_op(vm, 2'($urandom), $urandom, 5'($urandom), ($urandom_range(0, 7) == 0) ? 2 : 0, 1'b0);
        end

        // Leave rr_ptr at 1, then reset with an op in EXEC.
        do_op(2'b01, 2'b01, 32'hFFFF_0000, 5'd3, 0, 1'b0);
        req_valid = 2'b10;
        req_op1 = 2'b00; req_data1 = 32'h0000_00FF; req_shamt1 = 5'd8;
        #1;
        chk("pre_rst_grant", {30'd0, req_ready}, 32'd2);
        @(negedge clk);
        req_valid = 2'b11;
        rst_n = 1'b0;
        #1;
        chk("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_rsp_data", rsp_data, 32'd0);
        chk("midrst_rsp_id", {31'd0, rsp_id}, 32'd0);
        chk("midrst_ready", {30'd0, req_ready}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        req_valid = 2'b00;
        exp_prio = 0;
        @(negedge clk);
        #1;
        chk("post_rst_idle", {31'd0, rsp_valid}, 32'd0);
        do_op(2'b11, 2'b01, 32'h0000_0F00, 5'd8, 0, 1'b0);
        chk("post_rst_data", rsp_data, 32'h0000_000F);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
